// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and address helper for the register file
package rf_pkg;

    localparam int RF_WIDTH  = 16;
    localparam int RF_DEPTH  = 16;
    localparam int RF_NUM_RD = 2;

    // An address names real storage when it is inside the array and is not
    // the hardwired zero register.
    function automatic logic rf_addr_valid(
        input logic [31:0] addr,
        input logic [31:0] depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with masking and write bypass
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]                addr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  regs_i,
    input  logic [DEPTH-1:0]             busy_i,
    input  logic                         wr_en_i,
    input  logic [AW-1:0]                wr_addr_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         busy_o
);

    logic             addr_ok;
    logic [WIDTH-1:0] stored_data;
    logic             stored_busy;

    assign addr_ok = rf_addr_valid(32'(addr_i), 32'(DEPTH), ZERO_REG != 0);

    // Select the stored entry; addresses past DEPTH match nothing and read zero.
    always_comb begin
        stored_data = '0;
        stored_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(addr_i) == 32'(i)) begin
                stored_data = regs_i[i];
                stored_busy = busy_i[i];
            end
        end
    end

    // Mask invalid/zero addresses, then forward an in-flight write if enabled.
    always_comb begin
        data_o = '0;
        busy_o = 1'b0;
        if (addr_ok) begin
            if ((BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i)) begin
                data_o = wr_data_i;
            end else begin
                data_o = stored_data;
                busy_o = stored_busy;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-read-port register file with pending-write scoreboard
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    input  logic                    flush,
    output logic                    rsv_conflict
);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0]            busy_q;
    logic [DEPTH-1:0]            busy_d;
    logic [DEPTH-1:0]            wr_sel;
    logic [DEPTH-1:0]            rsv_sel;
    logic                        wr_ok;
    logic                        rsv_ok;
    logic                        conflict_q;
    logic                        conflict_d;

    assign wr_ok  = wr_en  & rf_addr_valid(32'(wr_addr),  32'(DEPTH), ZERO_REG != 0);
    assign rsv_ok = rsv_en & rf_addr_valid(32'(rsv_addr), 32'(DEPTH), ZERO_REG != 0);

    // One-hot decode of the write and reserve targets; invalid targets decode to nothing.
    always_comb begin
        wr_sel  = '0;
        rsv_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i]  = wr_ok  && (32'(wr_addr)  == 32'(i));
            rsv_sel[i] = rsv_ok && (32'(rsv_addr) == 32'(i));
        end
    end

    // Busy next state: flush clears all, a reserve beats a same-cycle writeback.
    always_comb begin
        busy_d     = (busy_q & ~wr_sel) | rsv_sel;
        conflict_d = ~flush & (|(rsv_sel & busy_q)) & ~(wr_en & (wr_addr == rsv_addr));
        if (flush) begin
            busy_d = '0;
        end
    end

    // Storage array; writes to invalid or zero addresses never reach it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    // Scoreboard bits and the one-cycle reserve-conflict pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign rsv_conflict = conflict_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr_i    (rd_addr[p*AW +: AW]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (rd_data[p*WIDTH +: WIDTH]),
            .busy_o    (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized and directed check of regfile_scoreboard against a reference model
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        flush;
    logic [11:0] rd_addr3;

    logic [31:0] rd_data0, rd_data1;
    logic [47:0] rd_data2;
    logic [1:0]  rd_busy0, rd_busy1;
    logic [2:0]  rd_busy2;
    logic        conf0, conf1, conf2;

    int n_checks = 0;
    int n_fail   = 0;

    // Three configurations: default, no bypass, short array with three ports.
    int   m_depth [3] = '{16, 16, 12};
    bit   m_byp   [3] = '{1'b1, 1'b0, 1'b1};
    int   m_nrd   [3] = '{2, 2, 3};
    logic [15:0] m_mem [3][16];
    bit   m_busy [3][16];
    bit   m_conf [3];

    regfile_scoreboard u0 (
        .clk(clk), .rst(rst_n), .rd_addr(rd_addr3[7:0]), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .rsv_conflict(conf0)
    );

    regfile_scoreboard #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst_n), .rd_addr(rd_addr3[7:0]), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .rsv_conflict(conf1)
    );

    regfile_scoreboard #(.DEPTH(12), .NUM_RD(3)) u2 (
        .clk(clk), .rst(rst_n), .rd_addr(rd_addr3), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .rsv_conflict(conf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(int c, int a);
        return (a < m_depth[c]) && (a != 0);
    endfunction

    function automatic logic [15:0] dut_data(int c, int p);
        case (c)
            0:       return rd_data0[p*16 +: 16];
            1:       return rd_data1[p*16 +: 16];
            default: return rd_data2[p*16 +: 16];
        endcase
    endfunction

    function automatic logic dut_busy(int c, int p);
        case (c)
            0:       return rd_busy0[p];
            1:       return rd_busy1[p];
            default: return rd_busy2[p];
        endcase
    endfunction

    function automatic logic dut_conf(int c);
        case (c)
            0:       return conf0;
            1:       return conf1;
            default: return conf2;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_conf[c] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_mem[c][i]  = '0;
                m_busy[c][i] = 1'b0;
            end
        end
    endtask

    // Compare every read port of every configuration with the model's view.
    task automatic check_reads(input string tag);
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < m_nrd[c]; p++) begin
                int a;
                logic [15:0] ed;
                logic eb;
                a = int'(rd_addr3[p*4 +: 4]);
                if (!addr_ok(c, a)) begin
                    ed = '0; eb = 1'b0;
                end else if (m_byp[c] && wr_en && (int'(wr_addr) == a)) begin
                    ed = wr_data; eb = 1'b0;
                end else begin
                    ed = m_mem[c][a]; eb = m_busy[c][a];
                end
                check_eq($sformatf("%s_data_c%0d_p%0d", tag, c, p), 32'(dut_data(c, p)), 32'(ed));
                check_eq($sformatf("%s_busy_c%0d_p%0d", tag, c, p), 32'(dut_busy(c, p)), 32'(eb));
            end
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            int wa, ra;
            wa = int'(wr_addr);
            ra = int'(rsv_addr);
            m_conf[c] = rsv_en && !flush && addr_ok(c, ra) && m_busy[c][ra] && !(wr_en && wa == ra);
            if (wr_en && addr_ok(c, wa)) m_mem[c][wa] = wr_data;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_busy[c][i] = 1'b0;
            end else begin
                if (wr_en && addr_ok(c, wa)) m_busy[c][wa] = 1'b0;
                if (rsv_en && addr_ok(c, ra)) m_busy[c][ra] = 1'b1;
            end
        end
    endtask

    task automatic set_in(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input logic re, input logic [3:0] ra, input logic fl,
                          input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; flush = fl;
        rd_addr3 = {a2, a1, a0};
        #1;
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic tick(input string tag);
        check_reads(tag);
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < 3; c++)
            check_eq($sformatf("%s_conf_c%0d", tag, c), 32'(dut_conf(c)), 32'(m_conf[c]));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Same-cycle write and read of r3.
        set_in(1, 3, 16'hBEEF, 0, 0, 0, 3, 0, 0);
        check_eq("t2_bypass", 32'(rd_data0[15:0]), 32'hBEEF);
        check_eq("t2_nobypass", 32'(rd_data1[15:0]), 32'h0);
        tick("t2a");
        set_in(0, 0, 0, 0, 0, 0, 3, 3, 3);
        check_eq("t2_after_byp", 32'(rd_data0[15:0]), 32'hBEEF);
        check_eq("t2_after_nobyp", 32'(rd_data1[15:0]), 32'hBEEF);
        tick("t2b");

        // Register zero ignores writes and reservations.
        set_in(1, 0, 16'h1234, 1, 0, 0, 0, 0, 0);
        check_eq("t3_r0_data", 32'(rd_data0[15:0]), 32'h0);
        tick("t3a");
        check_eq("t3_conf", 32'(conf0), 32'h0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t3_r0_busy", 32'(rd_busy0[0]), 32'h0);
        tick("t3b");

        // Reserve r5, then write it back.
        set_in(0, 0, 0, 1, 5, 0, 0, 5, 0);
        tick("t4a");
        set_in(0, 0, 0, 0, 0, 0, 0, 5, 0);
        check_eq("t4_busy_set", 32'(rd_busy0[1]), 32'h1);
        tick("t4b");
        set_in(1, 5, 16'h5555, 0, 0, 0, 0, 5, 0);
        check_eq("t4_busy_bypass", 32'(rd_busy0[1]), 32'h0);
        check_eq("t4_busy_nobyp", 32'(rd_busy1[1]), 32'h1);
        tick("t4c");
        set_in(0, 0, 0, 0, 0, 0, 0, 5, 0);
        check_eq("t4_busy_clear", 32'(rd_busy1[1]), 32'h0);
        tick("t4d");

        // Reserve beats write; a second reserve reports a conflict.
        set_in(1, 7, 16'h7777, 1, 7, 0, 7, 0, 0);
        tick("t5a");
        check_eq("t5_no_conf", 32'(conf0), 32'h0);
        set_in(0, 0, 0, 1, 7, 0, 7, 0, 0);
        check_eq("t5_busy7", 32'(rd_busy0[0]), 32'h1);
        tick("t5b");
        check_eq("t5_conf", 32'(conf0), 32'h1);
        set_in(0, 0, 0, 0, 0, 0, 7, 0, 0);
        tick("t5c");
        check_eq("t5_conf_drop", 32'(conf0), 32'h0);

        // Flush wins over a same-cycle reserve.
        set_in(0, 0, 0, 1, 2, 0, 2, 9, 4);
        tick("t6a");
        set_in(0, 0, 0, 1, 9, 0, 2, 9, 4);
        tick("t6b");
        set_in(0, 0, 0, 1, 4, 1, 2, 9, 4);
        tick("t6c");
        set_in(0, 0, 0, 0, 0, 0, 2, 9, 4);
        check_eq("t6_flush_busy", 32'(rd_busy2), 32'h0);
        check_eq("t6_flush_busy_u0", 32'(rd_busy0), 32'h0);
        tick("t6d");
        set_in(1, 13, 16'hABCD, 1, 13, 0, 13, 13, 13);
        check_eq("t6_oor_data", 32'(rd_data2), 32'h0);
        check_eq("t6_oor_busy", 32'(rd_busy2), 32'h0);
        tick("t6e");

        // Random traffic, read ports biased toward the write address.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] a [3];
            logic [3:0] wa;
            wa = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++)
                a[p] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            set_in(1'($urandom_range(0, 1)), wa, 16'($urandom),
                   ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 15) == 0), a[0], a[1], a[2]);
            tick("rnd");
        end

        // Asynchronous reset mid-run, away from the clock edge.
        set_in(0, 0, 0, 0, 0, 0, 4'($urandom_range(1, 11)), 4'($urandom_range(1, 11)),
               4'($urandom_range(1, 11)));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t1_data0", 32'(rd_data0), 32'h0);
        check_eq("t1_data1", 32'(rd_data1), 32'h0);
        check_eq("t1_data2", 32'(rd_data2), 32'h0);
        check_eq("t1_busy", {29'd0, rd_busy2}, 32'h0);
        check_eq("t1_busy01", {28'd0, rd_busy1, rd_busy0}, 32'h0);
        check_eq("t1_conf", {29'd0, conf2, conf1, conf0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        set_in(0, 0, 0, 0, 0, 0, 3, 5, 7);
        tick("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
